// File: rtl/load_store_unit_pkg.sv
// Shared constants, FSM state type and op-decode helpers for the load/store unit.
// Memory-interface count/code encodings mirror what memory_interface expects.
package load_store_unit_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE       = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [MEM_COUNT_W-1:0] f3_count(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return MEM_COUNT_BYTE;
      2'd1:    return MEM_COUNT_HALF;
      2'd2:    return MEM_COUNT_WORD;
      default: return MEM_COUNT_NONE;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] mask_store(input logic [WORD_W-1:0] data,
                                                   input logic [MEM_COUNT_W-1:0] count);
    case (count)
      MEM_COUNT_BYTE: return {24'd0, data[7:0]};
      MEM_COUNT_HALF: return {16'd0, data[15:0]};
      default:        return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_ext.sv
// Extends right-justified load data from memory to a full register word.
module load_store_unit_load_ext
  import load_store_unit_pkg::*;
(
  input  logic [WORD_W-1:0]      data,
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic                   is_unsigned,
  output logic [WORD_W-1:0]      ext
);

  // Sign- or zero-extension selected by access size.
  always_comb begin
    ext = data;
    case (count)
      MEM_COUNT_BYTE: begin
        if (is_unsigned) begin
          ext = {24'd0, data[7:0]};
        end else begin
          ext = {{24{data[7]}}, data[7:0]};
        end
      end
      MEM_COUNT_HALF: begin
        if (is_unsigned) begin
          ext = {16'd0, data[15:0]};
        end else begin
          ext = {{16{data[15]}}, data[15:0]};
        end
      end
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one op per handshake, one request to memory_interface,
// one registered result held for writeback.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_is_store,
  input  logic [2:0]             i_funct3,
  input  logic [ADDR_W-1:0]      i_base,
  input  logic [ADDR_W-1:0]      i_offset,
  input  logic [WORD_W-1:0]      i_store_data,
  input  logic [4:0]             i_rd,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  output logic                   o_req_wr_en,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [WORD_W-1:0]      o_res_data,
  output logic [4:0]             o_res_rd,
  output logic                   o_res_wr_rf,
  output logic                   o_res_misaligned,
  output logic                   o_res_illegal,
  output logic [ADDR_W-1:0]      o_res_addr
);

  lsu_state_e             state_r;
  logic                   is_store_r;
  logic                   is_unsigned_r;
  logic [MEM_COUNT_W-1:0] op_count_r;

  logic [ADDR_W-1:0]      eff_addr_s;
  logic                   legal_s;
  logic [MEM_COUNT_W-1:0] count_s;
  logic [WORD_W-1:0]      st_data_s;
  logic [WORD_W-1:0]      ext_data_s;
  logic [MEM_CODE_W-1:0]  exp_code_s;
  logic                   fault_s;

  // Decode of the op currently offered by execute.
  always_comb begin
    eff_addr_s = i_base + i_offset;
    legal_s    = f3_legal(i_is_store, i_funct3);
    count_s    = f3_count(i_funct3);
    st_data_s  = mask_store(i_store_data, count_s);
  end

  // Any response code other than the one matching the op is reported as misaligned.
  always_comb begin
    exp_code_s = is_store_r ? MEM_CODE_WRITE : MEM_CODE_READ;
    fault_s    = (i_res_code != exp_code_s);
  end

  load_store_unit_load_ext u_load_ext (
    .data        (i_res_rd_data),
    .count       (op_count_r),
    .is_unsigned (is_unsigned_r),
    .ext         (ext_data_s)
  );

  // Op sequencing and all registered outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r          <= ST_IDLE;
      is_store_r       <= 1'b0;
      is_unsigned_r    <= 1'b0;
      op_count_r       <= MEM_COUNT_NONE;
      o_ready          <= 1'b1;
      o_req_addr       <= {ADDR_W{1'b0}};
      o_req_wr_data    <= {WORD_W{1'b0}};
      o_req_count      <= MEM_COUNT_NONE;
      o_req_wr_en      <= 1'b0;
      o_res_valid      <= 1'b0;
      o_res_data       <= {WORD_W{1'b0}};
      o_res_rd         <= 5'd0;
      o_res_wr_rf      <= 1'b0;
      o_res_misaligned <= 1'b0;
      o_res_illegal    <= 1'b0;
      o_res_addr       <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            is_store_r       <= i_is_store;
            is_unsigned_r    <= i_funct3[2];
            op_count_r       <= count_s;
            o_ready          <= 1'b0;
            o_res_rd         <= i_rd;
            o_res_addr       <= eff_addr_s;
            o_res_data       <= {WORD_W{1'b0}};
            o_res_wr_rf      <= 1'b0;
            o_res_misaligned <= 1'b0;
            if (legal_s) begin
              o_req_addr    <= eff_addr_s;
              o_req_wr_data <= i_is_store ? st_data_s : {WORD_W{1'b0}};
              o_req_count   <= count_s;
              o_req_wr_en   <= i_is_store;
              o_res_illegal <= 1'b0;
              state_r       <= ST_REQ;
            end else begin
              // Illegal ops never reach memory; the result is ready at once.
              o_res_illegal <= 1'b1;
              o_res_valid   <= 1'b1;
              state_r       <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          o_req_count <= MEM_COUNT_NONE;
          o_req_wr_en <= 1'b0;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          o_res_valid <= 1'b1;
          state_r     <= ST_DONE;
          if (fault_s) begin
            o_res_misaligned <= 1'b1;
            o_res_data       <= {WORD_W{1'b0}};
            o_res_wr_rf      <= 1'b0;
          end else begin
            o_res_misaligned <= 1'b0;
            o_res_data       <= is_store_r ? {WORD_W{1'b0}} : ext_data_s;
            o_res_wr_rf      <= !is_store_r && (o_res_rd != 5'd0);
          end
        end
        ST_DONE: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            o_ready     <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          o_res_valid <= 1'b0;
          o_ready     <= 1'b1;
          o_req_count <= MEM_COUNT_NONE;
          o_req_wr_en <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-addressed memory model standing in
// for memory_interface (128 words).
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        i_valid, o_ready, i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_base, i_offset, i_store_data;
  logic [4:0]  i_rd;
  logic [31:0] o_req_addr, o_req_wr_data;
  logic [1:0]  o_req_count;
  logic        o_req_wr_en;
  logic [31:0] res_rd_data;
  logic [1:0]  res_code;
  logic        o_res_valid, i_res_ready;
  logic [31:0] o_res_data;
  logic [4:0]  o_res_rd;
  logic        o_res_wr_rf, o_res_misaligned, o_res_illegal;
  logic [31:0] o_res_addr;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [0:511];
  logic       mem_clear;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .aresetn(aresetn), .i_valid(i_valid), .o_ready(o_ready),
    .i_is_store(i_is_store), .i_funct3(i_funct3), .i_base(i_base), .i_offset(i_offset),
    .i_store_data(i_store_data), .i_rd(i_rd), .o_req_addr(o_req_addr),
    .o_req_wr_data(o_req_wr_data), .o_req_count(o_req_count), .o_req_wr_en(o_req_wr_en),
    .i_res_rd_data(res_rd_data), .i_res_code(res_code), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_res_data(o_res_data), .o_res_rd(o_res_rd),
    .o_res_wr_rf(o_res_wr_rf), .o_res_misaligned(o_res_misaligned),
    .o_res_illegal(o_res_illegal), .o_res_addr(o_res_addr)
  );

  // Memory model: registers one response per request cycle, rejects unaligned half/word.
  always @(posedge clk) begin
    logic [8:0]  a;
    int          nb;
    logic [31:0] rd;
    a  = o_req_addr[8:0];
    nb = (o_req_count == MEM_COUNT_BYTE) ? 1 : (o_req_count == MEM_COUNT_HALF) ? 2 : 4;
    rd = 32'h0;
    if (mem_clear) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      res_code    <= MEM_CODE_NONE;
      res_rd_data <= 32'h0;
    end else if (o_req_count == MEM_COUNT_NONE) begin
      res_code    <= MEM_CODE_NONE;
      res_rd_data <= 32'h0;
    end else if ((o_req_count == MEM_COUNT_HALF && a[0]) ||
                 (o_req_count == MEM_COUNT_WORD && a[1:0] != 2'd0)) begin
      res_code    <= MEM_CODE_MISALIGNED;
      res_rd_data <= 32'h0;
    end else if (o_req_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (k < nb) mem[9'(a + 9'(k))] <= o_req_wr_data[8*k +: 8];
      res_code    <= MEM_CODE_WRITE;
      res_rd_data <= 32'h0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (k < nb) rd[8*k +: 8] = mem[9'(a + 9'(k))];
      res_code    <= MEM_CODE_READ;
      res_rd_data <= rd;
    end
  end

  function automatic logic [75:0] res_snap();
    return {o_res_valid, o_res_data, o_res_rd, o_res_wr_rf, o_res_misaligned,
            o_res_illegal, o_res_addr, o_req_count, o_req_wr_en};
  endfunction

  // Issues one op; returns request seen right after accept and edges until result valid.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] data, input logic [4:0] rd,
                       output int lat, output logic [66:0] req);
    int n;
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL ready_wait got=%b exp=1", o_ready); end
    i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_base = base; i_offset = off;
    i_store_data = data; i_rd = rd;
    @(posedge clk); #1;
    i_valid = 1'b0;
    req = {o_req_count, o_req_wr_en, o_req_addr, o_req_wr_data};
    lat = 0;
    while (!o_res_valid && lat < 10) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume();
    @(negedge clk);
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
    total++;
    if ({o_res_valid, o_ready} !== 2'b01) begin
      bad++; $display("FAIL handoff got=%b exp=01", {o_res_valid, o_ready});
    end
  endtask

  task automatic test_reset();
    total++;
    if ({o_ready, o_req_addr, o_req_wr_data, res_snap()} !== {1'b1, 64'h0, 76'h0}) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", {o_ready, o_req_addr, o_req_wr_data, res_snap()},
               {1'b1, 64'h0, 76'h0});
    end
  endtask

  task automatic test_word();
    int lat; logic [66:0] req;
    do_op(1'b1, 3'd2, 32'h10, 32'h4, 32'hdeadbeef, 5'd3, lat, req);
    total++;
    if (req !== {MEM_COUNT_WORD, 1'b1, 32'h14, 32'hdeadbeef}) begin
      bad++; $display("FAIL sw_req got=%h exp=%h", req, {MEM_COUNT_WORD, 1'b1, 32'h14, 32'hdeadbeef});
    end
    total++;
    if (res_snap() !== {1'b1, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 32'h14, 2'd0, 1'b0}) begin
      bad++; $display("FAIL sw_res got=%h", res_snap());
    end
    consume();
    total++;
    if ({mem[9'h17], mem[9'h16], mem[9'h15], mem[9'h14]} !== 32'hdeadbeef) begin
      bad++; $display("FAIL sw_mem got=%h exp=deadbeef", {mem[9'h17], mem[9'h16], mem[9'h15], mem[9'h14]});
    end
    do_op(1'b0, 3'd2, 32'h10, 32'h4, 32'h0, 5'd5, lat, req);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++;
    if (req !== {MEM_COUNT_WORD, 1'b0, 32'h14, 32'h0}) begin
      bad++; $display("FAIL lw_req got=%h", req);
    end
    total++;
    if (res_snap() !== {1'b1, 32'hdeadbeef, 5'd5, 1'b1, 1'b0, 1'b0, 32'h14, 2'd0, 1'b0}) begin
      bad++; $display("FAIL lw_res got=%h", res_snap());
    end
    consume();
  endtask

  task automatic test_byte_half();
    int lat; logic [66:0] req;
    do_op(1'b1, 3'd0, 32'h20, 32'h1, 32'hffffff80, 5'd1, lat, req);
    total++;
    if (req !== {MEM_COUNT_BYTE, 1'b1, 32'h21, 32'h80}) begin bad++; $display("FAIL sb_req got=%h", req); end
    consume();
    do_op(1'b0, 3'd0, 32'h20, 32'h1, 32'h0, 5'd6, lat, req);
    total++;
    if (res_snap() !== {1'b1, 32'hffffff80, 5'd6, 1'b1, 1'b0, 1'b0, 32'h21, 2'd0, 1'b0}) begin
      bad++; $display("FAIL lb_res got=%h", res_snap());
    end
    consume();
    do_op(1'b0, 3'd4, 32'h20, 32'h1, 32'h0, 5'd7, lat, req);
    total++;
    if (o_res_data !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", o_res_data); end
    consume();
    do_op(1'b1, 3'd1, 32'h20, 32'h2, 32'h12348001, 5'd1, lat, req);
    total++;
    if (req !== {MEM_COUNT_HALF, 1'b1, 32'h22, 32'h8001}) begin bad++; $display("FAIL sh_req got=%h", req); end
    consume();
    do_op(1'b0, 3'd1, 32'h20, 32'h2, 32'h0, 5'd8, lat, req);
    total++;
    if (res_snap() !== {1'b1, 32'hffff8001, 5'd8, 1'b1, 1'b0, 1'b0, 32'h22, 2'd0, 1'b0}) begin
      bad++; $display("FAIL lh_res got=%h", res_snap());
    end
    consume();
    do_op(1'b0, 3'd5, 32'h20, 32'h2, 32'h0, 5'd9, lat, req);
    total++;
    if (o_res_data !== 32'h00008001) begin bad++; $display("FAIL lhu_data got=%h exp=00008001", o_res_data); end
    consume();
    total++;
    if ({mem[9'h23], mem[9'h22], mem[9'h21], mem[9'h20]} !== 32'h80018000) begin
      bad++; $display("FAIL half_mem got=%h exp=80018000", {mem[9'h23], mem[9'h22], mem[9'h21], mem[9'h20]});
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [66:0] req;
    do_op(1'b0, 3'd2, 32'h10, 32'h3, 32'h0, 5'd10, lat, req);
    total++;
    if (res_snap() !== {1'b1, 32'h0, 5'd10, 1'b0, 1'b1, 1'b0, 32'h13, 2'd0, 1'b0}) begin
      bad++; $display("FAIL lw_mis_res got=%h", res_snap());
    end
    consume();
    do_op(1'b1, 3'd2, 32'h10, 32'h3, 32'h11223344, 5'd2, lat, req);
    total++;
    if ({o_res_misaligned, o_res_addr} !== {1'b1, 32'h13}) begin
      bad++; $display("FAIL sw_mis_res got=%h exp=100000013", {o_res_misaligned, o_res_addr});
    end
    consume();
    total++;
    if ({mem[9'h17], mem[9'h16], mem[9'h15], mem[9'h14], mem[9'h13], mem[9'h12], mem[9'h11], mem[9'h10]}
        !== 64'hdeadbeef00000000) begin
      bad++; $display("FAIL sw_mis_mem got=%h exp=deadbeef00000000",
        {mem[9'h17], mem[9'h16], mem[9'h15], mem[9'h14], mem[9'h13], mem[9'h12], mem[9'h11], mem[9'h10]});
    end
    // Negative offset wraps; rd=0 must not request a register write.
    do_op(1'b0, 3'd2, 32'h18, 32'hfffffffc, 32'h0, 5'd0, lat, req);
    total++;
    if (res_snap() !== {1'b1, 32'hdeadbeef, 5'd0, 1'b0, 1'b0, 1'b0, 32'h14, 2'd0, 1'b0}) begin
      bad++; $display("FAIL lw_rd0_res got=%h", res_snap());
    end
    consume();
  endtask

  task automatic test_illegal();
    int lat; logic [66:0] req;
    do_op(1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 5'd11, lat, req);
    total++;
    if (lat !== 0) begin bad++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
    total++;
    if (req[66:64] !== {MEM_COUNT_NONE, 1'b0}) begin bad++; $display("FAIL illegal_req got=%h exp=0", req[66:64]); end
    total++;
    if (res_snap() !== {1'b1, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 32'h40, 2'd0, 1'b0}) begin
      bad++; $display("FAIL illegal_res got=%h", res_snap());
    end
    consume();
    do_op(1'b1, 3'd4, 32'h40, 32'h4, 32'h5, 5'd12, lat, req);
    total++;
    if ({lat, o_res_illegal, o_res_addr} !== {32'd0, 1'b1, 32'h44}) begin
      bad++; $display("FAIL illegal_store got lat=%0d ill=%b addr=%h", lat, o_res_illegal, o_res_addr);
    end
    consume();
  endtask

  task automatic test_hold_and_reset();
    int lat; logic [66:0] req;
    do_op(1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 5'd13, lat, req);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if ({o_ready, res_snap()} !== {1'b0, 1'b1, 32'hdeadbeef, 5'd13, 1'b1, 1'b0, 1'b0, 32'h14, 2'd0, 1'b0}) begin
        bad++; $display("FAIL hold_cycle%0d got=%h", c, {o_ready, res_snap()});
      end
    end
    consume();
    // Reset while the request is on the bus.
    @(negedge clk);
    i_valid = 1'b1; i_is_store = 1'b1; i_funct3 = 3'd2; i_base = 32'h30; i_offset = 32'h0;
    i_store_data = 32'h55; i_rd = 5'd4;
    @(posedge clk); #1;
    i_valid = 1'b0;
    total++;
    if (o_req_count !== MEM_COUNT_WORD) begin bad++; $display("FAIL mid_req got=%h exp=3", o_req_count); end
    aresetn = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    aresetn = 1'b1;
    do_op(1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 5'd14, lat, req);
    total++;
    if ({o_res_valid, o_res_data, o_res_rd} !== {1'b1, 32'hdeadbeef, 5'd14}) begin
      bad++; $display("FAIL after_reset got=%h", {o_res_valid, o_res_data, o_res_rd});
    end
    consume();
  endtask

  initial begin
    aresetn = 1'b0; mem_clear = 1'b1; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = 3'd0;
    i_base = 32'h0; i_offset = 32'h0; i_store_data = 32'h0; i_rd = 5'd0; i_res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    aresetn = 1'b1; mem_clear = 1'b0;
    test_word();
    test_byte_half();
    test_misaligned();
    test_illegal();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
